// File: rtl/reg_xfer_pkg.sv
// reg_xfer_pkg
//   Shared encodings for the register-transfer sequencer.
//   Contents:
//     op_t    : command opcodes carried on cmd_op
//     state_t : sequencer states
//   Configuration macro: REG_XFER_SWAP_EN.
//     When it is defined, the second write state ST_WR2 exists for SWAP.
//     When it is undefined, the state set is IDLE/RD/WR only.

package reg_xfer_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_READ = 2'b01,
        OP_MOVE = 2'b10,
        OP_SWAP = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
`ifdef REG_XFER_SWAP_EN
        , ST_WR2 = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/reg_onehot_dec.sv
// reg_onehot_dec
//   Turns a register index plus an enable into a one-hot strobe vector.
//   The output is all zeros when the enable is low or when the index is >= NREG.
//   Ports:
//     idx    in  AW    register index
//     en     in  1     decode enable
//     onehot out NREG  one-hot strobe vector
//   Configuration macro: none (REG_XFER_SWAP_EN does not affect this block).

module reg_onehot_dec #(
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic [AW-1:0]   idx,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    // Comparing against every legal index means an out-of-range index matches nothing.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < NREG; k++) begin
            onehot[k] = en && (idx == AW'(k));
        end
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl
//   Command-driven sequencer placed in front of NREG REG_16 registers.
//   It accepts one command at a time and drives one-hot W/RA/RB strobes and the write data.
//   It samples the shared OutA/OutB buses and returns the result of each READ.
//
//   Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
//   cmd_ready is high only in IDLE while rst is low.
//   rsp_valid and err are single-cycle pulses and have no back-pressure.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     cmd_valid/cmd_ready      command handshake
//     cmd_op                   00 LOAD, 01 READ, 10 MOVE, 11 SWAP
//     cmd_dst/src_a/src_b      register indices
//     cmd_imm                  immediate data for LOAD
//     reg_w/reg_ra/reg_rb      one-hot strobes to the registers
//     reg_i                    write data to the registers
//     bus_a/bus_b              shared register read buses
//     rsp_valid/rsp_a/rsp_b    READ result
//     err                      pulse when an accepted command is rejected
//
//   Configuration macro: REG_XFER_SWAP_EN.
//     Defined: op 11 performs SWAP as RD -> WR -> WR2.
//     Undefined: op 11 is rejected with an err pulse.

module reg_xfer_ctrl
    import reg_xfer_pkg::*;
#(
    parameter int NREG = 4,
    parameter int DW   = 16,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   cmd_dst,
    input  logic [AW-1:0]   cmd_src_a,
    input  logic [AW-1:0]   cmd_src_b,
    input  logic [DW-1:0]   cmd_imm,
    output logic [NREG-1:0] reg_w,
    output logic [NREG-1:0] reg_ra,
    output logic [NREG-1:0] reg_rb,
    output logic [DW-1:0]   reg_i,
    input  logic [DW-1:0]   bus_a,
    input  logic [DW-1:0]   bus_b,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_a,
    output logic [DW-1:0]   rsp_b,
    output logic            err
);

    state_t          state, state_n;
    op_t             op_q;
    logic [AW-1:0]   dst_q;
`ifdef REG_XFER_SWAP_EN
    logic [AW-1:0]   src_a_q, src_b_q;
    logic [DW-1:0]   tmp_a;
`endif

    logic            accept, cmd_ok;
    logic            w_en, ra_en, rb_en, err_n, rsp_n;
    logic [AW-1:0]   w_idx, ra_idx, rb_idx;
    logic [DW-1:0]   i_n;
    logic [NREG-1:0] w_dec, ra_dec, rb_dec;

    function automatic logic in_range(input logic [AW-1:0] idx);
        return int'(idx) < NREG;
    endfunction

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // Validity is checked only on the indices that the opcode actually uses.
    always_comb begin
        cmd_ok = 1'b0;
        case (op_t'(cmd_op))
            OP_LOAD: cmd_ok = in_range(cmd_dst);
            OP_READ: cmd_ok = in_range(cmd_src_a) && in_range(cmd_src_b);
            OP_MOVE: cmd_ok = in_range(cmd_src_a) && in_range(cmd_dst);
`ifdef REG_XFER_SWAP_EN
            OP_SWAP: cmd_ok = in_range(cmd_src_a) && in_range(cmd_src_b);
`endif
            default: cmd_ok = 1'b0;
        endcase
    end

    // This block computes the strobes for the *next* cycle; the flops below register them.
    // As a result, every reg_* output is driven straight from a flop.
    always_comb begin
        state_n = state;
        w_en    = 1'b0;
        ra_en   = 1'b0;
        rb_en   = 1'b0;
        w_idx   = '0;
        ra_idx  = '0;
        rb_idx  = '0;
        i_n     = '0;
        err_n   = 1'b0;
        rsp_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!cmd_ok) begin
                        err_n = 1'b1;
                    end else begin
                        case (op_t'(cmd_op))
                            OP_LOAD: begin
                                state_n = ST_WR;
                                w_en    = 1'b1;
                                w_idx   = cmd_dst;
                                i_n     = cmd_imm;
                            end
                            OP_MOVE: begin
                                state_n = ST_RD;
                                ra_en   = 1'b1;
                                ra_idx  = cmd_src_a;
                            end
                            default: begin // READ, and SWAP when it is compiled in
                                state_n = ST_RD;
                                ra_en   = 1'b1;
                                ra_idx  = cmd_src_a;
                                rb_en   = 1'b1;
                                rb_idx  = cmd_src_b;
                            end
                        endcase
                    end
                end
            end
            ST_RD: begin
                case (op_q)
                    OP_READ: begin
                        rsp_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                    OP_MOVE: begin
                        // The reg_i flop captures bus_a at this edge and holds it through WR.
                        state_n = ST_WR;
                        w_en    = 1'b1;
                        w_idx   = dst_q;
                        i_n     = bus_a;
                    end
`ifdef REG_XFER_SWAP_EN
                    OP_SWAP: begin
                        state_n = ST_WR;
                        w_en    = 1'b1;
                        w_idx   = src_a_q;
                        i_n     = bus_b;
                    end
`endif
                    default: state_n = ST_IDLE;
                endcase
            end
            ST_WR: begin
                state_n = ST_IDLE;
`ifdef REG_XFER_SWAP_EN
                if (op_q == OP_SWAP) begin
                    state_n = ST_WR2;
                    w_en    = 1'b1;
                    w_idx   = src_b_q;
                    i_n     = tmp_a;
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    reg_onehot_dec #(.NREG(NREG), .AW(AW)) u_dec_w  (.idx(w_idx),  .en(w_en),  .onehot(w_dec));
    reg_onehot_dec #(.NREG(NREG), .AW(AW)) u_dec_ra (.idx(ra_idx), .en(ra_en), .onehot(ra_dec));
    reg_onehot_dec #(.NREG(NREG), .AW(AW)) u_dec_rb (.idx(rb_idx), .en(rb_en), .onehot(rb_dec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            dst_q     <= '0;
            reg_w     <= '0;
            reg_ra    <= '0;
            reg_rb    <= '0;
            reg_i     <= '0;
            err       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_a     <= '0;
            rsp_b     <= '0;
`ifdef REG_XFER_SWAP_EN
            src_a_q   <= '0;
            src_b_q   <= '0;
            tmp_a     <= '0;
`endif
        end else begin
            state     <= state_n;
            reg_w     <= w_dec;
            reg_ra    <= ra_dec;
            reg_rb    <= rb_dec;
            reg_i     <= i_n;
            err       <= err_n;
            rsp_valid <= rsp_n;
            if (accept && cmd_ok) begin
                op_q    <= op_t'(cmd_op);
                dst_q   <= cmd_dst;
`ifdef REG_XFER_SWAP_EN
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
`endif
            end
            if (rsp_n) begin
                rsp_a <= bus_a;
                rsp_b <= bus_b;
            end
`ifdef REG_XFER_SWAP_EN
            if (state == ST_RD) begin
                tmp_a <= bus_a;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb_reg_xfer_ctrl
//   Bench for reg_xfer_ctrl with NREG=4 and DW=16.
//   The bench attaches a small model of four REG_16 registers to the strobes.
//   Every command pushes its expected per-cycle activity records into exp_q.
//   A negedge monitor pops those records and compares them with the DUT outputs.
//   Follows REG_XFER_SWAP_EN in the same way as the design.

module tb_reg_xfer_ctrl;

    localparam int NREG = 4;
    localparam int DW   = 16;
    localparam int AW   = 2;
    localparam int RW   = 62;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = '0;
    logic [AW-1:0]   cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
    logic [DW-1:0]   cmd_imm = '0;
    logic [NREG-1:0] reg_w, reg_ra, reg_rb;
    logic [DW-1:0]   reg_i, bus_a, bus_b, rsp_a, rsp_b;
    logic            rsp_valid, err;

    logic [DW-1:0]   mem   [NREG] = '{default: '0};
    logic [DW-1:0]   mem_e [NREG] = '{default: '0};
    logic [DW-1:0]   exp_ra = '0, exp_rb = '0;
    logic [RW-1:0]   exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;

    reg_xfer_ctrl #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
        .reg_w(reg_w), .reg_ra(reg_ra), .reg_rb(reg_rb), .reg_i(reg_i),
        .bus_a(bus_a), .bus_b(bus_b),
        .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b), .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- attached REG_16 model ----------------
    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (reg_w[k]) mem[k] <= reg_i;
        end
    end

    // The buses are OR-ed, so a multi-hot read enable corrupts the data that comes back.
    always @* begin
        bus_a = '0;
        bus_b = '0;
        for (int k = 0; k < NREG; k++) begin
            if (reg_ra[k]) bus_a = bus_a | mem[k];
            if (reg_rb[k]) bus_b = bus_b | mem[k];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rec(input logic [3:0] w, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [15:0] i,
                                          input logic rv, input logic er,
                                          input logic [15:0] a, input logic [15:0] b);
        return {w, ra, rb, i, rv, er, a, b};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [RW-1:0] act;
        if (!rst) begin
            act = {reg_w, reg_ra, reg_rb, reg_i, rsp_valid, err, rsp_a, rsp_b};
            check("w_onehot", 64'($countones(reg_w) <= 1), 64'd1);
            check("w_r_overlap", 64'((|reg_w) && (|{reg_ra, reg_rb})), 64'd0);
            check("i_zero", 64'((reg_w == '0) ? reg_i : '0), 64'd0);
            check("ready_busy", 64'(cmd_ready && (|{reg_w, reg_ra, reg_rb})), 64'd0);
            if (|{reg_w, reg_ra, reg_rb, rsp_valid, err}) begin
                if (exp_q.size() == 0) check("unexpected", 64'(act), 64'd0);
                else check("xfer", 64'(act), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    function automatic void expect_cmd(input logic [1:0] op, input logic [1:0] dst,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [15:0] imm);
        logic [3:0]  one = 4'b0001;
        logic [15:0] va, vb;
        va = mem_e[a];
        vb = mem_e[b];
        case (op)
            2'b00: begin
                exp_q.push_back(rec(one << dst, 4'b0, 4'b0, imm, 1'b0, 1'b0, exp_ra, exp_rb));
                mem_e[dst] = imm;
            end
            2'b01: begin
                exp_q.push_back(rec(4'b0, one << a, one << b, 16'h0, 1'b0, 1'b0, exp_ra, exp_rb));
                exp_ra = va;
                exp_rb = vb;
                exp_q.push_back(rec(4'b0, 4'b0, 4'b0, 16'h0, 1'b1, 1'b0, exp_ra, exp_rb));
            end
            2'b10: begin
                exp_q.push_back(rec(4'b0, one << a, 4'b0, 16'h0, 1'b0, 1'b0, exp_ra, exp_rb));
                exp_q.push_back(rec(one << dst, 4'b0, 4'b0, va, 1'b0, 1'b0, exp_ra, exp_rb));
                mem_e[dst] = va;
            end
            default: begin
`ifdef REG_XFER_SWAP_EN
                exp_q.push_back(rec(4'b0, one << a, one << b, 16'h0, 1'b0, 1'b0, exp_ra, exp_rb));
                exp_q.push_back(rec(one << a, 4'b0, 4'b0, vb, 1'b0, 1'b0, exp_ra, exp_rb));
                exp_q.push_back(rec(one << b, 4'b0, 4'b0, va, 1'b0, 1'b0, exp_ra, exp_rb));
                mem_e[a] = vb;
                mem_e[b] = va;
`else
                exp_q.push_back(rec(4'b0, 4'b0, 4'b0, 16'h0, 1'b0, 1'b1, exp_ra, exp_rb));
`endif
            end
        endcase
    endfunction

    // Call this task at a negedge. It leaves cmd_valid high, so consecutive calls run back-to-back.
    task automatic send(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] a,
                        input logic [1:0] b, input logic [15:0] imm);
        int guard = 0;
        cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        expect_cmd(op, dst, a, b, imm);
        @(negedge clk);
        check("latency", 64'(|{reg_w, reg_ra, reg_rb, err}), 64'd1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_outs", 64'({reg_w, reg_ra, reg_rb, reg_i, rsp_valid, err, rsp_a, rsp_b}), 64'd0);
        rst = 1'b0;
        #1 check("rst_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);

        // Directed tests: LOAD, READ, MOVE, SWAP (or its rejection), then MOVE with src_a==dst.
        send(2'b00, 2'd1, 2'd0, 2'd0, 16'h0099);
        send(2'b00, 2'd2, 2'd0, 2'd0, 16'h0555);
        idle(2);
        send(2'b01, 2'd0, 2'd1, 2'd2, 16'h0);
        idle(2);
        send(2'b10, 2'd3, 2'd1, 2'd0, 16'h0);
        idle(2);
        send(2'b00, 2'd0, 2'd0, 2'd0, 16'h1111);
        send(2'b00, 2'd2, 2'd0, 2'd0, 16'h2222);
        send(2'b11, 2'd0, 2'd0, 2'd2, 16'h0);
        idle(2);
        send(2'b10, 2'd3, 2'd3, 2'd0, 16'h0);
        send(2'b11, 2'd1, 2'd1, 2'd1, 16'h0);

        // Back-to-back LOAD, READ, MOVE with cmd_valid held high.
        send(2'b00, 2'd3, 2'd0, 2'd0, 16'hbeef);
        send(2'b01, 2'd0, 2'd3, 2'd0, 16'h0);
        send(2'b10, 2'd1, 2'd3, 2'd0, 16'h0);
        idle(2);

        // Random mix.
        for (int n = 0; n < 40; n++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 16'($urandom_range(0, 16'hffff)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        send(2'b01, 2'd0, 2'd2, 2'd3, 16'h0);
        idle(3);

        // Assert reset during the RD cycle of a MOVE: the destination must not be written.
        cmd_op = 2'b10; cmd_src_a = 2'd0; cmd_dst = 2'd2; cmd_valid = 1'b1;
        exp_q.push_back(rec(4'b0, 4'b0001, 4'b0, 16'h0, 1'b0, 1'b0, exp_ra, exp_rb));
        @(negedge clk);
        #2 rst = 1'b1;
        cmd_valid = 1'b0;
        #1 check("rst_mid_strobes", 64'({reg_w, reg_ra, reg_rb, reg_i}), 64'd0);
        check("rst_mid_rsp", 64'({rsp_valid, err, rsp_a, rsp_b}), 64'd0);
        exp_ra = '0;
        exp_rb = '0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        idle(4);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < NREG; k++) begin
            check($sformatf("mem%0d", k), 64'(mem[k]), 64'(mem_e[k]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
